// File: rtl/lb_window_ctrl.sv
// Sequences three line buffers into a 3x3 window stream: fills one line per burst,
// then issues per-column reads and hands windows downstream over valid/ready.
module lb_window_ctrl #(
    parameter int LINE_BYTES  = 100,
    parameter int WORDS       = 25,
    parameter int FRAME_LINES = 28,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic [2:0]        lb_wr_en,
    output logic [31:0]       lb_wr_data,
    output logic              lb_rd_en,
    output logic [ADDR_W-1:0] lb_rd_addr,
    input  logic [2:0]        lb_data_valid,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [1:0]        win_top,
    output logic [ADDR_W-1:0] win_col,
    output logic [4:0]        win_row,
    output logic              frame_done,
    output logic              err_underrun
);

    localparam logic [2:0] S_FLUSH    = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_WR_ARM   = 3'd2;
    localparam logic [2:0] S_WR_BURST = 3'd3;
    localparam logic [2:0] S_WR_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_ISSUE = 3'd5;
    localparam logic [2:0] S_RD_WAIT  = 3'd6;
    localparam logic [2:0] S_WIN_OUT  = 3'd7;

    localparam int CNT_W = $clog2(WORDS + 3);
    localparam logic [CNT_W-1:0]  FLUSH_INIT = CNT_W'(WORDS + 2);
    localparam logic [CNT_W-1:0]  WCNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(LINE_BYTES - 3);
    localparam logic [4:0]        LINE_LAST  = 5'(FRAME_LINES);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0]  r_wcnt;
    logic [4:0]        r_line;
    logic [1:0]        r_wr_sel;
    logic [1:0]        r_top;
    logic [ADDR_W-1:0] r_col;
    logic              r_rd_first;
    logic              r_frame_done;
    logic              r_err;

    logic [4:0]        w_line_nxt;
    logic [1:0]        w_wr_sel_nxt;
    logic [1:0]        w_top_nxt;

    assign w_line_nxt   = r_line + 5'd1;
    assign w_wr_sel_nxt = (r_wr_sel == 2'd2) ? 2'd0 : r_wr_sel + 2'd1;
    assign w_top_nxt    = (r_top == 2'd2) ? 2'd0 : r_top + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FLUSH;
            r_flush_cnt  <= FLUSH_INIT;
            r_wcnt       <= '0;
            r_line       <= '0;
            r_wr_sel     <= '0;
            r_top        <= '0;
            r_col        <= '0;
            r_rd_first   <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                // A buffer may still be mid-burst from before reset; let it drain.
                S_FLUSH: begin
                    if (r_flush_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (frame_start) begin
                        r_err    <= 1'b0;
                        r_line   <= '0;
                        r_wr_sel <= '0;
                        r_top    <= '0;
                        r_state  <= S_WR_ARM;
                    end
                end
                S_WR_ARM: begin
                    r_wcnt  <= '0;
                    r_state <= S_WR_BURST;
                end
                S_WR_BURST: begin
                    if (!in_valid) begin
                        r_err <= 1'b1;
                    end
                    r_wcnt <= r_wcnt + CNT_W'(1);
                    if (r_wcnt == WCNT_LAST) begin
                        r_state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    r_line   <= w_line_nxt;
                    r_wr_sel <= w_wr_sel_nxt;
                    if (w_line_nxt < 5'd3) begin
                        r_state <= S_WR_ARM;
                    end else begin
                        r_col   <= '0;
                        r_state <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    r_rd_first <= 1'b1;
                    r_state    <= S_RD_WAIT;
                end
                // data_valid still shows the previous read during the first cycle.
                S_RD_WAIT: begin
                    r_rd_first <= 1'b0;
                    if (!r_rd_first && lb_data_valid == 3'b111) begin
                        r_state <= S_WIN_OUT;
                    end
                end
                S_WIN_OUT: begin
                    if (win_ready) begin
                        if (r_col < COL_LAST) begin
                            r_col   <= r_col + ADDR_W'(1);
                            r_state <= S_RD_ISSUE;
                        end else if (r_line == LINE_LAST) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_top   <= w_top_nxt;
                            r_state <= S_WR_ARM;
                        end
                    end
                end
                default: r_state <= S_FLUSH;
            endcase
        end
    end

    assign in_ready     = (r_state == S_WR_BURST);
    assign lb_wr_en     = (r_state == S_WR_ARM) ? (3'b001 << r_wr_sel) : 3'b000;
    assign lb_wr_data   = in_data;
    assign lb_rd_en     = (r_state == S_RD_ISSUE);
    assign lb_rd_addr   = r_col;
    assign win_valid    = (r_state == S_WIN_OUT);
    assign win_top      = r_top;
    assign win_col      = r_col;
    assign win_row      = win_valid ? (r_line - 5'd3) : 5'd0;
    assign frame_done   = r_frame_done;
    assign err_underrun = r_err;

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Bench for lb_window_ctrl: line-buffer model, upstream driver, window scoreboard,
// a first-frame timing table and directed stall/underrun/reset sequences.
module tb_lb_window_ctrl;
    localparam int LINE_BYTES  = 100;
    localparam int WORDS       = 25;
    localparam int FRAME_LINES = 28;
    localparam int ADDR_W      = 7;
    localparam int COLS        = LINE_BYTES - 2;
    localparam int ROWS        = FRAME_LINES - 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_ready;
    logic [2:0]        lb_wr_en;
    logic [31:0]       lb_wr_data;
    logic              lb_rd_en;
    logic [ADDR_W-1:0] lb_rd_addr;
    logic [2:0]        lb_data_valid;
    logic              win_valid;
    logic              win_ready = 1'b0;
    logic [1:0]        win_top;
    logic [ADDR_W-1:0] win_col;
    logic [4:0]        win_row;
    logic              frame_done;
    logic              err_underrun;

    lb_window_ctrl #(.LINE_BYTES(LINE_BYTES), .WORDS(WORDS), .FRAME_LINES(FRAME_LINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lb_wr_en(lb_wr_en), .lb_wr_data(lb_wr_data),
        .lb_rd_en(lb_rd_en), .lb_rd_addr(lb_rd_addr), .lb_data_valid(lb_data_valid),
        .win_valid(win_valid), .win_ready(win_ready), .win_top(win_top),
        .win_col(win_col), .win_row(win_row),
        .frame_done(frame_done), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] top;
        logic [4:0] row;
        logic [6:0] col;
    } win_t;

    typedef struct {
        int         cyc;
        logic       rdy;
        logic [2:0] wr_en;
        logic       in_rdy;
        logic       rd_en;
        logic       win_vld;
        logic [6:0] addr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_win   = 0;
    int n_done  = 0;
    int wl = 0, wk = 0, run = 0;
    bit drop_arm = 1'b0;
    win_t exp_q[$];

    logic [63:0] all_outs;
    assign all_outs = {3'b000, in_ready, lb_wr_en, lb_wr_data, lb_rd_en, lb_rd_addr, win_valid,
                       win_top, win_col, win_row, frame_done, err_underrun};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int l, input int x);
        return 8'((l * 37 + x * 3 + 5) & 255);
    endfunction

    // Three line buffers: 25-word capture after each write pulse, read data valid 2 cycles after a read pulse.
    logic [7:0] mem [3][LINE_BYTES];
    int   wr_buf = 0, wr_left = 0;
    logic rd_d1 = 1'b0, rd_v = 1'b1;
    assign lb_data_valid = {3{rd_v}};

    always @(posedge clk) begin
        if (lb_wr_en != 3'b000) begin
            wr_buf  <= lb_wr_en[1] ? 1 : (lb_wr_en[2] ? 2 : 0);
            wr_left <= WORDS;
        end else if (wr_left > 0) begin
            for (int j = 0; j < 4; j++) mem[wr_buf][(WORDS - wr_left) * 4 + j] <= lb_wr_data[8*j +: 8];
            wr_left <= wr_left - 1;
        end
        rd_d1 <= lb_rd_en;
        if (lb_rd_en) rd_v <= 1'b0;
        else if (rd_d1) rd_v <= 1'b1;
    end

    // Upstream driver plus scoreboard, one step per cycle just after the falling edge.
    initial begin
        win_t e;
        int   t0, c;
        bit   ok, acc, last_acc;
        last_acc = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                in_valid = 1'b0;
                in_data  = '0;
                run      = 0;
                last_acc = 1'b0;
            end else begin
                if (lb_wr_en != 3'b000)
                    chk("wr_trigger", {59'd0, lb_wr_en, in_ready, 1'(wk == 0)},
                        {59'd0, 3'(1 << (wl % 3)), 1'b0, 1'b1});
                if (in_ready) begin
                    in_valid = !(drop_arm && wl == 0 && wk == 12);
                    for (int j = 0; j < 4; j++) in_data[8*j +: 8] = pix(wl, 4 * wk + j);
                    run++;
                    wk++;
                    if (wk == WORDS) begin
                        wk = 0;
                        wl++;
                    end
                end else begin
                    if (run != 0) begin
                        chk("burst_len", 64'(run), 64'(WORDS));
                        run = 0;
                    end
                    in_valid = 1'b0;
                    in_data  = '0;
                end
                acc = win_valid && win_ready;
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_window", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("win", {43'd0, win_top, win_row, win_col, lb_rd_addr},
                            {43'd0, e.top, e.row, e.col, e.col});
                        t0 = int'(e.top);
                        c  = int'(e.col);
                        ok = mem[t0][c] == pix(e.row, c) &&
                             mem[(t0 + 1) % 3][c + 1] == pix(e.row + 1, c + 1) &&
                             mem[(t0 + 2) % 3][c + 2] == pix(e.row + 2, c + 2);
                        chk("win_pixels", 64'(ok), 64'(1));
                    end
                    n_win++;
                end
                if (frame_done) begin
                    n_done++;
                    chk("frame_done", {62'd0, last_acc, 1'(exp_q.size() == 0)}, 64'd3);
                end
                last_acc = acc;
            end
        end
    end

    function automatic vec_t mk(input int cyc, input logic [2:0] we, input logic ir, input logic re,
                                input logic wv, input logic [6:0] a);
        vec_t v;
        v.cyc = cyc; v.rdy = 1'b1; v.wr_en = we; v.in_rdy = ir;
        v.rd_en = re; v.win_vld = wv; v.addr = a;
        return v;
    endfunction

    // Called right after a falling edge while the DUT is idle.
    task automatic begin_frame();
        frame_start = 1'b1;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back('{2'(r % 3), 5'(r), 7'(c)});
        wl = 0;
        wk = 0;
        n_win = 0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        begin_frame();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm, input bit rnd);
        int d0, t;
        d0 = n_done;
        t  = 0;
        while (n_done == d0 && t < budget) begin
            @(negedge clk);
            if (rnd) win_ready = ($urandom_range(0, 3) != 0);
            t++;
        end
        win_ready = 1'b1;
        if (n_done == d0) chk({nm, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        vec_t tbl[21];
        int   cyc, t, bad;

        tbl[0]  = mk(0,  3'b000, 0, 0, 0, 0);
        tbl[1]  = mk(1,  3'b001, 0, 0, 0, 0);
        tbl[2]  = mk(2,  3'b000, 1, 0, 0, 0);
        tbl[3]  = mk(26, 3'b000, 1, 0, 0, 0);
        tbl[4]  = mk(27, 3'b000, 0, 0, 0, 0);
        tbl[5]  = mk(28, 3'b010, 0, 0, 0, 0);
        tbl[6]  = mk(29, 3'b000, 1, 0, 0, 0);
        tbl[7]  = mk(53, 3'b000, 1, 0, 0, 0);
        tbl[8]  = mk(54, 3'b000, 0, 0, 0, 0);
        tbl[9]  = mk(55, 3'b100, 0, 0, 0, 0);
        tbl[10] = mk(56, 3'b000, 1, 0, 0, 0);
        tbl[11] = mk(80, 3'b000, 1, 0, 0, 0);
        tbl[12] = mk(81, 3'b000, 0, 0, 0, 0);
        tbl[13] = mk(82, 3'b000, 0, 1, 0, 0);
        tbl[14] = mk(83, 3'b000, 0, 0, 0, 0);
        tbl[15] = mk(84, 3'b000, 0, 0, 0, 0);
        tbl[16] = mk(85, 3'b000, 0, 0, 1, 0);
        tbl[17] = mk(86, 3'b000, 0, 1, 0, 1);
        tbl[18] = mk(89, 3'b000, 0, 0, 1, 1);
        tbl[19] = mk(90, 3'b000, 0, 1, 0, 2);
        tbl[20] = mk(93, 3'b000, 0, 0, 1, 2);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs, 64'd0);
        rst = 1'b0;
        repeat (WORDS + 8) @(negedge clk);

        // Frame A: first-frame timing from the table, then the full frame with win_ready held high.
        win_ready = 1'b1;
        @(negedge clk);
        begin_frame();
        cyc = 0;
        for (int i = 0; i < 21; i++) begin
            while (cyc < tbl[i].cyc) begin
                @(negedge clk);
                frame_start = 1'b0;
                cyc++;
            end
            win_ready = tbl[i].rdy;
            chk($sformatf("vec%0d_cyc%0d", i, tbl[i].cyc),
                {47'd0, lb_wr_en, in_ready, lb_rd_en, win_valid, lb_rd_addr, win_col},
                {47'd0, tbl[i].wr_en, tbl[i].in_rdy, tbl[i].rd_en, tbl[i].win_vld, tbl[i].addr, tbl[i].addr});
        end
        wait_done(20000, "frameA", 1'b0);
        chk("A_windows", 64'(n_win), 64'(ROWS * COLS));
        chk("A_done_count", 64'(n_done), 64'(1));
        chk("A_err", 64'(err_underrun), 64'(0));

        // Frame B: ignored frame_start in a burst, stall at col 40, then random win_ready.
        start_frame();
        t = 0;
        while (!in_ready && t < 10) begin @(negedge clk); t++; end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("B_fs_in_burst", {62'd0, in_ready, err_underrun}, 64'd2);
        t = 0;
        while (!(lb_rd_en && lb_rd_addr == 7'd40) && t < 2000) begin @(negedge clk); t++; end
        chk("B_reach_col40", 64'(t < 2000), 64'(1));
        win_ready = 1'b0;
        t = 0;
        while (!win_valid && t < 10) begin @(negedge clk); t++; end
        for (int i = 0; i < 10; i++) begin
            chk("B_stall_hold", {45'd0, win_valid, win_col, lb_rd_addr, lb_rd_en, win_row},
                {45'd0, 1'b1, 7'd40, 7'd40, 1'b0, 5'd0});
            frame_start = (i == 3);
            @(negedge clk);
        end
        frame_start = 1'b0;
        win_ready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!lb_rd_en && t < 10);
        chk("B_after_stall", {56'd0, lb_rd_en, lb_rd_addr}, {56'd0, 1'b1, 7'd41});
        wait_done(40000, "frameB", 1'b1);
        chk("B_windows", 64'(n_win), 64'(ROWS * COLS));
        chk("B_done_count", 64'(n_done), 64'(2));
        chk("B_err", 64'(err_underrun), 64'(0));

        // Frame C: in_valid dropped at word 12 of line 0.
        drop_arm = 1'b1;
        start_frame();
        t = 0;
        while (wl < 1 && t < 100) begin @(negedge clk); t++; end
        chk("C_err_set", 64'(err_underrun), 64'(1));
        t = 0;
        while (!in_ready && t < 10) begin @(negedge clk); t++; end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("C_fs_in_burst", {62'd0, in_ready, err_underrun}, 64'd3);
        wait_done(20000, "frameC", 1'b0);
        drop_arm = 1'b0;
        chk("C_windows", 64'(n_win), 64'(ROWS * COLS));
        chk("C_err_sticky", 64'(err_underrun), 64'(1));

        // Frame D: frame_start clears the flag; reset at word 10 of line 4.
        start_frame();
        chk("D_err_cleared", 64'(err_underrun), 64'(0));
        t = 0;
        while (!(wl == 4 && wk == 10) && t < 1000) begin @(negedge clk); t++; end
        chk("D_reach_line4", 64'(t < 1000), 64'(1));
        rst = 1'b1;
        #2;
        chk("D_reset_outputs", all_outs, 64'd0);
        exp_q.delete();
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < WORDS + 2; i++) begin
            if (i == 0) rst = 1'b0;
            frame_start = 1'b1;
            if (in_ready || lb_wr_en != 3'b000) bad++;
            @(negedge clk);
        end
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready || lb_wr_en != 3'b000) bad++;
            @(negedge clk);
        end
        chk("D_flush_ignores_start", 64'(bad), 64'(0));
        chk("D_no_done", 64'(n_done), 64'(3));

        // Frame E: clean frame after the mid-frame reset.
        start_frame();
        wait_done(20000, "frameE", 1'b0);
        chk("E_windows", 64'(n_win), 64'(ROWS * COLS));
        chk("E_done_count", 64'(n_done), 64'(4));
        chk("E_err", 64'(err_underrun), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
